mem_responder: RTL and testbench

Memory-side responder for the multicycle MIPS32 control unit's instruction/data accesses. It is a unified, word-organised instruction/data RAM with programmable wait states and a valid/ready request plus single-cycle response handshake. It sits opposite the control FSM and datapath:
- The datapath drives the request address (PC or ALUOut), selected by IorD.
- MemWrite/IRWrite sequencing is converted into requests.
- Each request returns read data or a write acknowledge after a fixed latency.

---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_mem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Unified word-organised instruction/data RAM for a multicycle MIPS32 core.
// Each request is accepted in IDLE. After WAIT_CYCLES wait states the
// response is a single-cycle pulse carrying either read data or a write
// acknowledge. Only one transaction is in flight at a time.
//
// Parameters
//   DEPTH        number of DW-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait-state cycles between acceptance and response (0..15)
//   DW           data width (32 for MIPS32)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   req_valid   in   request present this cycle
//   req_write   in   1 = store word, 0 = load word / instruction fetch
//   req_addr    in   byte address
//   req_wdata   in   store data
//   req_ready   out  responder accepts a request this cycle (IDLE)
//   resp_valid  out  one-cycle response pulse
//   resp_rdata  out  load data, zero for writes and errors
//   resp_err    out  misaligned or out-of-range access
//   busy        out  transaction in flight
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          busy
);

    localparam int IW = $clog2(DEPTH);

    // A zero-wait build goes straight from IDLE to RESP. In that build the
    // counter is never used.
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Word-aligned and inside the array. Upper address bits must be zero,
    // so accesses never alias onto a lower word.
    function automatic logic addr_fault(input logic [31:0] a);
        logic misaligned;
        logic out_of_range;
        misaligned   = (a[1:0] != 2'b00);
        out_of_range = |a[31:IW+2];
        return misaligned | out_of_range;
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic           write_q, write_d;
    logic [DW-1:0]  wdata_q, wdata_d;

    logic           ready_q;
    logic           resp_valid_q;
    logic [DW-1:0]  resp_rdata_q;
    logic           resp_err_q;
    logic           busy_q;

    logic           enter_resp_s;
    logic           err_s;
    logic [IW-1:0]  idx_s;
    logic           mem_we_s;

    logic [DW-1:0]  mem [DEPTH];

    // Next-state logic, wait counter and request latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    if (ZERO_WAIT) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The memory operation happens on the edge that enters RESP.
    // The *_d fields are used here because a zero-wait build latches and
    // executes on the same edge. In WAIT the *_d fields equal the latched
    // *_q values, so the request inputs are not consulted there.
    always_comb begin
        enter_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
        err_s        = addr_fault(addr_d);
        idx_s        = addr_d[IW+1:2];
        // A write is dropped while reset is held. A reset in WAIT then
        // leaves the RAM untouched.
        mem_we_s     = enter_resp_s & write_d & ~err_s & ~reset;
    end

    // State, counter and latched request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            wdata_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    // Registered handshake and response outputs, derived from the next state.
    // Reset clears resp_valid asynchronously, even in the middle of RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DW{1'b0}};
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ready_q      <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            resp_valid_q <= enter_resp_s;
            resp_err_q   <= enter_resp_s & err_s;
            if (enter_resp_s && !write_d && !err_s) begin
                resp_rdata_q <= mem[idx_s];
            end else begin
                resp_rdata_q <= {DW{1'b0}};
            end
        end
    end

    // RAM array. Its contents are not reset, so they survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[idx_s] <= wdata_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A uses WAIT_CYCLES = 2. Instance Z uses WAIT_CYCLES = 0.
    logic        rv_a, rw_a, rdy_a, v_a, e_a, bsy_a;
    logic [31:0] ra_a, rwd_a, d_a;
    logic        rv_z, rw_z, rdy_z, v_z, e_z, bsy_z;
    logic [31:0] ra_z, rwd_z, d_z;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .DW(32)) u_dut (
        .clk(clk), .reset(reset), .req_valid(rv_a), .req_write(rw_a),
        .req_addr(ra_a), .req_wdata(rwd_a), .req_ready(rdy_a),
        .resp_valid(v_a), .resp_rdata(d_a), .resp_err(e_a), .busy(bsy_a));

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .DW(32)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv_z), .req_write(rw_z),
        .req_addr(ra_z), .req_wdata(rwd_z), .req_ready(rdy_z),
        .resp_valid(v_z), .resp_rdata(d_z), .resp_err(e_z), .busy(bsy_z));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference memories, keyed by word number. Words never written are unknown.
    logic [31:0] model_a [int];
    logic [31:0] model_z [int];

    function automatic bit addr_bad(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    // Packs {ready, valid, err, busy, rdata} for the selected instance.
    function automatic logic [35:0] outs(input bit sel);
        return sel ? {rdy_z, v_z, e_z, bsy_z, d_z} : {rdy_a, v_a, e_a, bsy_a, d_a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input bit v, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            rv_z = v; rw_z = wr; ra_z = a; rwd_z = wd;
        end else begin
            rv_a = v; rw_a = wr; ra_a = a; rwd_a = wd;
        end
    endtask

    // One complete transaction, with the latency and pulse shape checked against the model.
    task automatic do_req(input bit sel, input bit wr, input logic [31:0] addr, input logic [31:0] wd, input string name);
        int          w;
        int          guard;
        logic [35:0] o;
        logic [31:0] exp_d;
        bit          exp_e;
        bit          known;
        w     = sel ? 0 : 2;
        exp_e = addr_bad(addr);
        exp_d = 32'd0;
        known = 1'b1;
        if (!exp_e && !wr) begin
            if (sel) begin
                known = model_z.exists(int'(addr / 4));
                if (known) exp_d = model_z[int'(addr / 4)];
            end else begin
                known = model_a.exists(int'(addr / 4));
                if (known) exp_d = model_a[int'(addr / 4)];
            end
        end
        guard = 0;
        o = outs(sel);
        while (o[35] !== 1'b1 && guard < 20) begin
            step();
            guard++;
            o = outs(sel);
        end
        n_vec++;
        if (o[35] !== 1'b1) begin
            n_miss++;
            $display("FAIL %s ready_timeout got %b exp 1", name, o[35]);
        end
        drive(sel, 1'b1, wr, addr, wd);
        step();
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < w; i++) begin
            o = outs(sel);
            n_vec++;
            if (o[34] !== 1'b0 || o[35] !== 1'b0 || o[32] !== 1'b1) begin
                n_miss++;
                $display("FAIL %s wait_phase got v=%b rdy=%b busy=%b exp v=0 rdy=0 busy=1", name, o[34], o[35], o[32]);
            end
            step();
        end
        o = outs(sel);
        n_vec++;
        if (o[34] !== 1'b1 || o[35] !== 1'b0 || o[32] !== 1'b1) begin
            n_miss++;
            $display("FAIL %s resp_pulse got v=%b rdy=%b busy=%b exp v=1 rdy=0 busy=1", name, o[34], o[35], o[32]);
        end
        n_vec++;
        if (o[33] !== exp_e) begin
            n_miss++;
            $display("FAIL %s resp_err got %b exp %b", name, o[33], exp_e);
        end
        if (known) begin
            n_vec++;
            if (o[31:0] !== exp_d) begin
                n_miss++;
                $display("FAIL %s resp_rdata got %h exp %h", name, o[31:0], exp_d);
            end
        end
        if (wr && !exp_e) begin
            if (sel) model_z[int'(addr / 4)] = wd;
            else     model_a[int'(addr / 4)] = wd;
        end
        step();
        o = outs(sel);
        n_vec++;
        if (o[34] !== 1'b0 || o[33] !== 1'b0 || o[31:0] !== 32'd0 || o[35] !== 1'b1 || o[32] !== 1'b0) begin
            n_miss++;
            $display("FAIL %s after_resp got v=%b e=%b d=%h rdy=%b busy=%b exp 0 0 0 1 0", name, o[34], o[33], o[31:0], o[35], o[32]);
        end
    endtask

    task automatic test_reset();
        logic [35:0] o;
        reset = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            o = outs(s[0]);
            n_vec++;
            if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
                n_miss++;
                $display("FAIL reset_state got %h exp %h", o, {1'b1, 35'd0});
            end
        end
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            o = outs(1'b0);
            n_vec++;
            if (o !== {1'b1, 35'd0}) begin
                n_miss++;
                $display("FAIL idle_hold got %h exp %h", o, {1'b1, 35'd0});
            end
        end
    endtask

    task automatic test_write_read();
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_0x10");
        do_req(1'b0, 1'b0, 32'h10, 32'h0, "rd_0x10");
    endtask

    // req_valid is held high. Acceptances must come every 4 cycles and responses in order.
    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] exp_d;
        int          last;
        int          n_acc;
        int          n_rsp;
        bit          acc;
        do_req(1'b0, 1'b1, 32'h0, 32'h11111111, "pre_0x0");
        do_req(1'b0, 1'b1, 32'h4, 32'h22222222, "pre_0x4");
        last = 0; n_acc = 0; n_rsp = 0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 40 && n_rsp < 4; c++) begin
            acc = rdy_a;
            step();
            if (v_a === 1'b1) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
                n_rsp++;
                n_vec++;
                if (d_a !== exp_d) begin
                    n_miss++;
                    $display("FAIL b2b_data got %h exp %h", d_a, exp_d);
                end
            end
            if (acc) begin
                if (n_acc > 0) begin
                    n_vec++;
                    if (c - last !== 4) begin
                        n_miss++;
                        $display("FAIL b2b_spacing got %0d exp 4", c - last);
                    end
                end
                exp_q.push_back(model_a[int'(ra_a / 4)]);
                last = c;
                n_acc++;
                if (n_acc < 4) ra_a = ra_a ^ 32'h4;
                else           rv_a = 1'b0;
            end else if (n_acc > 0) begin
                n_vec++;
                if (rdy_a !== ((c - last) == 3)) begin
                    n_miss++;
                    $display("FAIL b2b_ready got %b exp %b", rdy_a, ((c - last) == 3));
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_vec++;
        if (n_rsp !== 4) begin
            n_miss++;
            $display("FAIL b2b_count got %0d exp 4", n_rsp);
        end
        step();
    endtask

    task automatic test_boundary();
        do_req(1'b0, 1'b1, 32'hFC, $urandom, "wr_last");
        do_req(1'b0, 1'b1, 32'h102, 32'hCAFEF00D, "wr_misaligned");
        do_req(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, "wr_out_of_range");
        do_req(1'b0, 1'b0, 32'h0, 32'h0, "rd_0x0_no_alias");
        do_req(1'b0, 1'b0, 32'hFC, 32'h0, "rd_last");
        do_req(1'b0, 1'b0, 32'h100, 32'h0, "rd_out_of_range");
    endtask

    task automatic test_reset_mid();
        logic [31:0] nv;
        do_req(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, "pre_0x8");
        // A reset during WAIT discards the write and produces no response.
        drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h12345678);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (v_a !== 1'b0 || bsy_a !== 1'b0) begin
                n_miss++;
                $display("FAIL reset_in_wait got v=%b busy=%b exp 0 0", v_a, bsy_a);
            end
            step();
        end
        reset = 1'b0;
        step();
        do_req(1'b0, 1'b0, 32'h8, 32'h0, "rd_0x8_after_reset");
        // A reset during RESP keeps the write and drops resp_valid at once.
        nv = $urandom;
        drive(1'b0, 1'b1, 1'b1, 32'h20, nv);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        n_vec++;
        if (v_a !== 1'b1) begin
            n_miss++;
            $display("FAIL resp_before_reset got %b exp 1", v_a);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (v_a !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_in_resp got v=%b exp 0", v_a);
        end
        model_a[8] = nv;
        step();
        reset = 1'b0;
        step();
        do_req(1'b0, 1'b0, 32'h20, 32'h0, "rd_0x20_kept");
    endtask

    task automatic test_zero_wait();
        int last;
        int n_acc;
        bit acc;
        do_req(1'b1, 1'b1, 32'h4, $urandom, "z_wr_0x4");
        do_req(1'b1, 1'b0, 32'h4, 32'h0, "z_rd_0x4");
        last = 0; n_acc = 0;
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int c = 1; c <= 20 && n_acc < 4; c++) begin
            acc = rdy_z;
            step();
            if (acc) begin
                n_vec++;
                if (v_z !== 1'b1 || d_z !== model_z[1]) begin
                    n_miss++;
                    $display("FAIL z_b2b_resp got v=%b d=%h exp 1 %h", v_z, d_z, model_z[1]);
                end
                if (n_acc > 0) begin
                    n_vec++;
                    if (c - last !== 2) begin
                        n_miss++;
                        $display("FAIL z_b2b_spacing got %0d exp 2", c - last);
                    end
                end
                last = c;
                n_acc++;
            end
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        n_vec++;
        if (n_acc !== 4) begin
            n_miss++;
            $display("FAIL z_b2b_count got %0d exp 4", n_acc);
        end
        step();
        step();
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h100 + 32'($urandom_range(0, 1000)) * 32'd4;
            else             a = $urandom | 32'h8000_0000;
            do_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom, "random");
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        test_zero_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
